// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  mem_arb_pkg
//  Shared types and constants for the instruction/data memory port arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    // Counter is sized for the largest legal latency so any MEM_LAT in 1..8 fits.
    localparam int MEM_LAT_MAX = 8;
    localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

`default_nettype wire

// File: rtl/arb_lat_counter.sv
// ============================================================================
//  arb_lat_counter
//  Loads MEM_LAT-1 on issue, counts down to zero and flags the completion cycle.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module arb_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(MEM_LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  mem_port_arbiter
//  Shares one single-ported memory between instruction fetch and load/store.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic              if_kill,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int ST_W = $clog2(STARVE_MAX + 1);

    state_e          state_q;
    owner_e          owner_q;
    logic [ST_W-1:0] starve_q;
    logic            kill_q;
    logic            we_q;

    logic cnt_zero;
    logic done;
    logic can_issue;
    logic starved;
    logic issue;

    assign done      = (state_q == S_WAIT) && cnt_zero;
    assign can_issue = !rst_n && ((state_q == S_IDLE) || done);
    assign starved   = (starve_q == ST_W'(STARVE_MAX));

    // A killed fetch never competes, so data may take the slot instead.
    assign if_gnt = can_issue && if_req && !if_kill && (starved || !d_req);
    assign d_gnt  = can_issue && d_req && !if_gnt;
    assign issue  = if_gnt || d_gnt;

    assign mem_en    = issue;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = (d_gnt && d_we) ? d_wdata : '0;

    assign if_rvalid = done && (owner_q == OWN_IF) && !kill_q && !if_kill;
    assign d_rvalid  = done && (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

    assign stall_if  = !rst_n && if_req && !if_rvalid;
    assign stall_mem = !rst_n && d_req && !d_rvalid;

    arb_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .rst    (rst_n),
        .load_i (issue),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
            kill_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            if (issue) begin
                state_q <= S_WAIT;
                owner_q <= if_gnt ? OWN_IF : OWN_D;
                we_q    <= d_gnt && d_we;
            end else if (done) begin
                state_q <= S_IDLE;
                owner_q <= OWN_NONE;
                we_q    <= 1'b0;
            end

            // Remember a flush that lands between issue and completion of a fetch.
            if (done || issue) begin
                kill_q <= 1'b0;
            end else if ((state_q == S_WAIT) && (owner_q == OWN_IF) && if_kill) begin
                kill_q <= 1'b1;
            end

            if (!if_req || if_gnt) begin
                starve_q <= '0;
            end else if (d_gnt && !starved) begin
                starve_q <= starve_q + ST_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the IF-stage instruction fetch and the MEM-stage load/store. It keeps at most one memory transaction outstanding and returns fixed-latency responses, data first. It drives stall_if/stall_mem, which the hazard logic ORs into the PC/IF_ID enables and into the pipeline freeze.

Parameters:
ADDR_W, 32, address width of both requesters and the memory
DATA_W, 32, data width
MEM_LAT, 2, cycles from issue cycle to mem_rdata valid; legal values 1..8
STARVE_MAX, 4, max consecutive data grants while if_req is pending before fetch is forced

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-high (asserted when 1; port name per codebase convention)
if_req  in  1  fetch request; held with if_addr until if_rvalid or if_kill
if_kill  in  1  branch flush: discard outstanding/pending fetch
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch issued to memory this cycle
if_rvalid  out  1  fetch response valid (1-cycle pulse)
if_rdata  out  DATA_W  instruction word, valid with if_rvalid
d_req  in  1  load/store request; held with d_we, d_addr and d_wdata until d_rvalid
d_we  in  1  1 = store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data access issued this cycle
d_rvalid  out  1  load data / store ack valid (1-cycle pulse)
d_rdata  out  DATA_W  load data; 0 for stores
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
stall_if  out  1  if_req & ~if_rvalid
stall_mem  out  1  d_req & ~d_rvalid

Behaviour:
- Reset (async, any state): FSM goes to IDLE; owner=NONE; latency counter=0; starvation counter=0. All outputs are 0 while rst=1. An in-flight transaction is abandoned and no rvalid is produced.
- FSM states: IDLE and WAIT. An issue cycle is any cycle in which a grant fires. Issue is legal in IDLE, and in WAIT on the cycle whose response completes, which allows back-to-back issue (one transaction per MEM_LAT cycles).
- Issue: exactly one of if_gnt/d_gnt is 1. mem_en=1 and mem_addr/mem_we/mem_wdata are driven combinationally from the winner. owner is registered, the counter loads MEM_LAT-1, and the FSM moves to WAIT.
- WAIT: the counter decrements each cycle. Completion cycle = issue cycle + MEM_LAT (with MEM_LAT=1, completion is the next cycle). On completion the owner's rvalid is 1 and rdata = mem_rdata (combinational pass-through); d_rdata is 0 for stores. The FSM then returns to IDLE unless it issues again that cycle.
- Arbitration: data wins by default. Fetch wins instead when the starvation counter equals STARVE_MAX and if_req=1.
- Starvation counter: +1 per data grant while if_req=1. Cleared on a fetch grant or when if_req=0. Saturates at STARVE_MAX.
- if_kill, fetch outstanding: the memory access completes, but if_rvalid is suppressed. A kill_pending flag is set and cleared at completion.
- if_kill on an issue cycle in which fetch would win: fetch is not granted and data may win that cycle.
- if_kill when the owner is data: no effect on the data transaction.
- Requester drops req while outstanding: this is a protocol violation. The response pulse is still emitted and the arbiter does not hang.
- Stores are acknowledged with d_rvalid at completion, with the same latency as loads.

Decomposition:
- mem_arb_pkg holds:
  - owner enum: OWN_NONE, OWN_IF, OWN_D
  - state enum: S_IDLE, S_WAIT
  - localparam CNT_W = clog2(MEM_LAT+1)
- One natural sub-module, arb_lat_counter: load/decrement/zero-detect latency counter, parameterised by MEM_LAT.

Test Plan:
- MEM_LAT=2. Single fetch: if_req=1 with addr 0x40 at cycle 0, mem_rdata=0x00500093 at cycle 2 -> if_gnt at cycle 0; if_rvalid and if_rdata=0x00500093 at cycle 2; stall_if=1 in cycles 0-1 and 0 in cycle 2.
- Simultaneous if_req and d_req (load 0x100) at cycle 0 -> d_gnt at 0, d_rvalid at 2, if_gnt at 2, if_rvalid at 4.
- STARVE_MAX=2, d_req held high for 4 back-to-back loads, if_req high -> grants in order D, D, IF, D at cycles 0, 2, 4, 6.
- Fetch issued at cycle 0, if_kill at cycle 1 -> mem_en only at 0; if_rvalid stays 0 at cycle 2; a new fetch issued at cycle 2 returns normally at cycle 4.
- Store d_we=1, addr 0x80, wdata 0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF at issue; d_rvalid=1 and d_rdata=0 at issue+MEM_LAT.
- Reset asserted at cycle 1 of an outstanding load -> all outputs 0 immediately; no d_rvalid after release; the next request issues from IDLE.
